// File: rtl/xbar_switch.sv
`default_nettype none
// ============================================================================
// Module   : xbar_switch
// Purpose  : N-port single-word packet crossbar. Each input buffers packets in
//            a small FIFO. The head packet's top DW bits select the output.
//            Each output has a round-robin arbiter and a registered output
//            stage with pass-through backpressure.
// Ports    : clk, rst (synchronous, active-low)
//            s_valid/s_ready/s_data : per-input valid/ready packet ingress
//            m_valid/m_ready/m_data : per-output registered packet egress
//            port p uses bit p, or slice [p*DATA_W +: DATA_W]
// Revision : 1.0 - initial parametrised release
// ============================================================================
module xbar_switch #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS-1:0]        s_valid,
  output logic [PORTS-1:0]        s_ready,
  input  logic [PORTS*DATA_W-1:0] s_data,
  output logic [PORTS-1:0]        m_valid,
  input  logic [PORTS-1:0]        m_ready,
  output logic [PORTS*DATA_W-1:0] m_data
);

  localparam int DW = $clog2(PORTS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Input FIFO state
  logic [DATA_W-1:0] mem    [PORTS][DEPTH];
  logic [AW-1:0]     wr_ptr [PORTS];
  logic [AW-1:0]     rd_ptr [PORTS];
  logic [CW-1:0]     count  [PORTS];
  logic [DATA_W-1:0] head   [PORTS];
  logic [DW-1:0]     dest   [PORTS];
  logic [PORTS-1:0]  req;
  logic [PORTS-1:0]  push;
  logic [PORTS-1:0]  pop;

  // Output / arbitration state
  logic [DW-1:0]     ptr      [PORTS];
  logic [DW-1:0]     gnt_idx  [PORTS];
  logic [PORTS-1:0]  gnt_v;
  logic [PORTS-1:0]  load_ok;
  logic [PORTS-1:0]  out_valid;
  logic [DATA_W-1:0] out_data [PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      // Ready comes only from the registered count. Holding it low during
      // reset means no handshake can be seen on a reset edge.
      assign s_ready[gi] = rst && (count[gi] != CW'(DEPTH));
      assign push[gi]    = s_valid[gi] && s_ready[gi];
      // No bypass: a word becomes requestable the cycle after it is written.
      assign req[gi]     = (count[gi] != '0);
      assign head[gi]    = mem[gi][rd_ptr[gi]];
      assign dest[gi]    = head[gi][DATA_W-1 -: DW];
      assign load_ok[gi] = !out_valid[gi] || m_ready[gi];
      assign m_data[gi*DATA_W +: DATA_W] = out_data[gi];
    end
  endgenerate

  assign m_valid = out_valid;

  // Round-robin search per output. It starts at ptr[d] and wraps at PORTS,
  // using natural DW-bit overflow. Each input targets exactly one output, so
  // the grants across outputs never collide on one input.
  always_comb begin
    logic          found;
    logic [DW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    gnt_v = '0;
    pop   = '0;
    for (int d = 0; d < PORTS; d++) begin
      gnt_idx[d] = '0;
    end
    for (int d = 0; d < PORTS; d++) begin
      found = 1'b0;
      for (int k = 0; k < PORTS; k++) begin
        idx = ptr[d] + DW'(k);
        if (!found && req[idx] && (dest[idx] == DW'(d))) begin
          found      = 1'b1;
          gnt_idx[d] = idx;
        end
      end
      gnt_v[d] = found && load_ok[d];
    end
    for (int d = 0; d < PORTS; d++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (gnt_v[d] && (gnt_idx[d] == DW'(i))) begin
          pop[i] = 1'b1;
        end
      end
    end
  end

  // FIFO storage needs no reset. The count and pointers define the contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (!rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CW'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < PORTS; d++) begin
      if (!rst) begin
        out_valid[d] <= 1'b0;
        out_data[d]  <= '0;
        ptr[d]       <= '0;
      end else if (gnt_v[d]) begin
        out_valid[d] <= 1'b1;
        out_data[d]  <= head[gnt_idx[d]];
        ptr[d]       <= gnt_idx[d] + DW'(1);
      end else if (m_ready[d]) begin
        out_valid[d] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
